// File: rtl/spi_burst_bridge_if.sv
// Signal bundle between spi_burst_bridge and its environment (SPI host and GPU bus).
// master: the bridge itself (drives MISO and bus strobes); slave: host and bus responder.
interface spi_burst_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_spi_cs_n;
  logic                  i_spi_mosi;
  logic                  o_spi_miso;
  logic                  o_bus_we;
  logic                  o_bus_re;
  logic [ADDR_WIDTH-1:0] o_bus_addr;
  logic [DATA_WIDTH-1:0] o_bus_wdata;
  logic                  i_bus_rvalid;
  logic [DATA_WIDTH-1:0] i_bus_rdata;
  logic                  o_busy;
  logic                  o_rd_timeout;

  modport master (
    input  i_spi_cs_n, i_spi_mosi, i_bus_rvalid, i_bus_rdata,
    output o_spi_miso, o_bus_we, o_bus_re, o_bus_addr, o_bus_wdata, o_busy, o_rd_timeout
  );

  modport slave (
    output i_spi_cs_n, i_spi_mosi, i_bus_rvalid, i_bus_rdata,
    input  o_spi_miso, o_bus_we, o_bus_re, o_bus_addr, o_bus_wdata, o_busy, o_rd_timeout
  );
endinterface

// File: rtl/spi_burst_bridge.sv
// SPI mode-0 slave to parallel bus bridge: CMD/ADDR decode, burst writes, and burst reads
// with one word of prefetch so read data streams on MISO without gaps.
module spi_burst_bridge #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          DUMMY_CYCLES = 8,
  parameter int          ADDR_STRIDE  = 4,
  parameter logic [31:0] ERR_PATTERN  = 32'hDEAD_BEEF
) (
  input logic               i_spi_clk,
  input logic               rst_n,
  spi_burst_bridge_if.master io
);
  localparam int SW   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CMAX = (SW > DUMMY_CYCLES) ? SW : DUMMY_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0]         CMD_LAST   = CW'(7);
  localparam logic [CW-1:0]         ADDR_LAST  = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]         DATA_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]         DUMMY_LAST = CW'(DUMMY_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD   = DATA_WIDTH'(ERR_PATTERN);
  localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [3:0]            word_cnt_q, word_cnt_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [SW-1:0]         sh_q, sh_d;
  logic [ADDR_WIDTH-1:0] nxt_addr_q, nxt_addr_d;
  logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;
  logic                  rd_got_q, rd_got_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;

  logic [SW-1:0]         sh_in;
  logic                  rd_hit, rd_have, load_word, issue_re;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] re_addr;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    cmd_d      = cmd_q;
    sh_d       = sh_q;
    nxt_addr_d = nxt_addr_q;
    rd_buf_d   = rd_buf_q;
    rd_got_d   = rd_got_q;
    rd_pend_d  = rd_pend_q;
    timeout_d  = timeout_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    load_word  = 1'b0;
    issue_re   = 1'b0;
    re_addr    = nxt_addr_q;
    sh_in      = {sh_q[SW-2:0], io.i_spi_mosi};
    // Read data is accepted anywhere in the dummy window, but not on a word-reload edge.
    rd_hit  = !io.i_spi_cs_n && rd_pend_q && io.i_bus_rvalid &&
              ((state_q == S_DUMMY) || ((state_q == S_RDATA) && (bit_cnt_q != DATA_LAST)));
    rd_have = rd_got_q || rd_hit;
    rd_word = rd_hit ? io.i_bus_rdata : rd_buf_q;
    if (rd_hit) begin
      rd_buf_d  = io.i_bus_rdata;
      rd_got_d  = 1'b1;
      rd_pend_d = 1'b0;
    end

    if (io.i_spi_cs_n) begin
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      rd_got_d   = 1'b0;
      rd_pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_d      = {7'd0, io.i_spi_mosi};
          bit_cnt_d  = CW'(1);
          word_cnt_d = '0;
          timeout_d  = 1'b0;
          state_d    = S_CMD;
        end
        S_CMD: begin
          cmd_d     = {cmd_q[6:0], io.i_spi_mosi};
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CMD_LAST) begin
            bit_cnt_d = '0;
            state_d   = (cmd_d[6:4] != 3'd0) ? S_DONE : S_ADDR;
          end
        end
        S_ADDR: begin
          sh_d      = sh_in;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            nxt_addr_d = sh_in[ADDR_WIDTH-1:0];
            if (cmd_q[7]) begin
              state_d = S_WDATA;
            end else begin
              state_d  = S_DUMMY;
              issue_re = 1'b1;
              re_addr  = sh_in[ADDR_WIDTH-1:0];
            end
          end
        end
        S_WDATA: begin
          sh_d      = sh_in;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d  = '0;
            we_d       = 1'b1;
            addr_d     = nxt_addr_q;
            wdata_d    = sh_in[DATA_WIDTH-1:0];
            nxt_addr_d = nxt_addr_q + STRIDE;
            word_cnt_d = word_cnt_q + 4'd1;
            if (word_cnt_q == cmd_q[3:0]) state_d = S_DONE;
          end
        end
        S_DUMMY: begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == DUMMY_LAST) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            state_d    = S_RDATA;
            load_word  = 1'b1;
            issue_re   = (cmd_q[3:0] != 4'd0);
          end
        end
        S_RDATA: begin
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (word_cnt_q == cmd_q[3:0]) begin
              state_d = S_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 4'd1;
              load_word  = 1'b1;
              issue_re   = ((word_cnt_q + 4'd1) != cmd_q[3:0]);
            end
          end
        end
        default: ;
      endcase
    end

    if (load_word) begin
      sh_d      = SW'(rd_have ? rd_word : ERR_WORD);
      timeout_d = timeout_q | !rd_have;
      rd_got_d  = 1'b0;
      rd_pend_d = 1'b0;
    end
    // Prefetch: request the next word while the current one is still shifting out.
    if (issue_re) begin
      re_d       = 1'b1;
      addr_d     = re_addr;
      nxt_addr_d = re_addr + STRIDE;
      rd_pend_d  = 1'b1;
      rd_got_d   = 1'b0;
    end
  end

  always_ff @(posedge i_spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      cmd_q      <= '0;
      sh_q       <= '0;
      nxt_addr_q <= '0;
      rd_buf_q   <= '0;
      rd_got_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      timeout_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      cmd_q      <= cmd_d;
      sh_q       <= sh_d;
      nxt_addr_q <= nxt_addr_d;
      rd_buf_q   <= rd_buf_d;
      rd_got_q   <= rd_got_d;
      rd_pend_q  <= rd_pend_d;
      timeout_q  <= timeout_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
    end
  end

  assign io.o_spi_miso   = (state_q == S_RDATA) ? sh_q[DATA_WIDTH-1] : 1'b0;
  assign io.o_bus_we     = we_q;
  assign io.o_bus_re     = re_q;
  assign io.o_bus_addr   = addr_q;
  assign io.o_bus_wdata  = wdata_q;
  assign io.o_busy       = (state_q != S_IDLE);
  assign io.o_rd_timeout = timeout_q;
endmodule

// File: tb/tb_spi_burst_bridge.sv
// Bench for spi_burst_bridge: SPI host driver, latency-randomised bus responder,
// and a frame-level reference model (expected bus traffic and MISO words per frame).
module tb_spi_burst_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DC = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_burst_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif ();

  spi_burst_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DUMMY_CYCLES(DC), .ADDR_STRIDE(4), .ERR_PATTERN(ERR)
  ) dut (
    .i_spi_clk(clk),
    .rst_n    (rst_n),
    .io       (sif.master)
  );

  int n_tests = 0;
  int n_fail = 0;

  int          lat_lo = 1;
  int          lat_hi = 7;
  bit          never_resp = 1'b0;
  logic [31:0] salt = '0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [31:0] re_a[$];
  logic [31:0] wbuf[16];
  logic [31:0] rwords[16];
  int          miso_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus side: log strobes, answer each read request after a random latency with addr^salt.
  always @(negedge clk) begin
    sif.i_bus_rvalid = 1'b0;
    sif.i_bus_rdata  = $urandom;
    if (sif.o_bus_we === 1'b1) begin
      wr_a.push_back(sif.o_bus_addr);
      wr_d.push_back(sif.o_bus_wdata);
    end
    if (sif.o_bus_re === 1'b1) begin
      re_a.push_back(sif.o_bus_addr);
      pend_addr = sif.o_bus_addr;
      lat_cnt   = never_resp ? 0 : $urandom_range(lat_hi, lat_lo);
    end
    if (lat_cnt == 1) begin
      sif.i_bus_rvalid = 1'b1;
      sif.i_bus_rdata  = pend_addr ^ salt;
      lat_cnt = 0;
    end else if (lat_cnt > 1) begin
      lat_cnt--;
    end
  end

  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] addr, input int abort_at,
                          output int total);
    bit is_wr, rsv;
    int nw, rd0, p;
    is_wr = cmd[7];
    rsv   = (cmd[6:4] != 3'd0);
    nw    = int'(cmd[3:0]) + 1;
    rd0   = 8 + AW + DC;
    total = rsv ? 8 + AW + 16 : (is_wr ? 8 + AW + nw * DW : rd0 + nw * DW);
    if (abort_at > 0 && abort_at < total) total = abort_at;
    wr_a.delete();
    wr_d.delete();
    re_a.delete();
    miso_bad = 0;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("timeout_clr_at_start", 32'(sif.o_rd_timeout), 32'd0);
        check("busy_in_frame", 32'(sif.o_busy), 32'd1);
      end
      sif.i_spi_cs_n = 1'b0;
      if (i < 8) sif.i_spi_mosi = cmd[7-i];
      else if (i < 8 + AW) sif.i_spi_mosi = addr[AW-1-(i-8)];
      else if (is_wr && !rsv) begin
        p = i - 8 - AW;
        sif.i_spi_mosi = wbuf[p/DW][DW-1-(p%DW)];
      end else sif.i_spi_mosi = 1'($urandom_range(1, 0));
      if (!is_wr && !rsv && i >= rd0) begin
        p = i - rd0;
        rwords[p/DW] = {rwords[p/DW][DW-2:0], sif.o_spi_miso};
      end else if (sif.o_spi_miso !== 1'b0) begin
        miso_bad++;
      end
    end
    @(negedge clk);
    sif.i_spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Reference model: a frame is judged by its complete bus transaction list and MISO words.
  task automatic run_check(input logic [7:0] cmd, input logic [31:0] addr, input int abort_at);
    int total, nw, done_w;
    bit is_wr, rsv;
    logic [31:0] ea;
    nw    = int'(cmd[3:0]) + 1;
    is_wr = cmd[7];
    rsv   = (cmd[6:4] != 3'd0);
    do_frame(cmd, addr, abort_at, total);
    if (rsv) begin
      check("rsv_we_count", 32'(wr_a.size()), 32'd0);
      check("rsv_re_count", 32'(re_a.size()), 32'd0);
    end else if (is_wr) begin
      done_w = (total < 8 + AW) ? 0 : (total - 8 - AW) / DW;
      if (done_w > nw) done_w = nw;
      check("wr_count", 32'(wr_a.size()), 32'(done_w));
      check("re_in_write", 32'(re_a.size()), 32'd0);
      for (int k = 0; k < done_w && k < wr_a.size(); k++) begin
        ea = addr + 32'(4 * k);
        check("wr_addr", wr_a[k], ea);
        check("wr_data", wr_d[k], wbuf[k]);
      end
    end else begin
      check("re_count", 32'(re_a.size()), 32'(nw));
      for (int k = 0; k < nw; k++) begin
        ea = addr + 32'(4 * k);
        if (k < re_a.size()) check("re_addr", re_a[k], ea);
        check("rd_word", rwords[k], never_resp ? ERR : (ea ^ salt));
      end
      check("rd_timeout", 32'(sif.o_rd_timeout), 32'(never_resp));
    end
    check("miso_zero_outside_rdata", 32'(miso_bad), 32'd0);
    check("busy_after_frame", 32'(sif.o_busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  c;
    logic [31:0] a;
    int          ab, len;
    sif.i_spi_cs_n = 1'b1;
    sif.i_spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({sif.o_bus_we, sif.o_bus_re, sif.o_spi_miso, sif.o_busy, sif.o_rd_timeout}),
          32'd0);
    check("rst_addr", sif.o_bus_addr, 32'd0);
    check("rst_wdata", sif.o_bus_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    wbuf[0] = 32'h0000_00A1;
    wbuf[1] = 32'h0000_00B2;
    run_check(8'h81, 32'h0000_1000, 0);

    lat_lo = 3; lat_hi = 3; salt = 32'h1234_5678 ^ 32'h20;
    run_check(8'h00, 32'h0000_0020, 0);

    lat_lo = 1; lat_hi = 7; salt = '0;
    run_check(8'h03, 32'h0000_0400, 0);

    never_resp = 1'b1;
    run_check(8'h00, 32'h0000_0080, 0);
    never_resp = 1'b0;

    wbuf[0] = 32'h1111_2222;
    wbuf[1] = 32'h3333_4444;
    run_check(8'h81, 32'h0000_2000, 8 + AW + DW + 20);

    run_check(8'h70, 32'h0000_0000, 0);

    for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
    run_check(8'h83, 32'hFFFF_FFF8, 0);

    // Async reset in the middle of an address phase.
    c = 8'h83;
    a = 32'h0000_0500;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sif.i_spi_cs_n = 1'b0;
      sif.i_spi_mosi = (i < 8) ? c[7-i] : a[AW-1-(i-8)];
    end
    @(negedge clk);
    check("busy_before_reset", 32'(sif.o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_ctl",
             32'({sif.o_bus_we, sif.o_bus_re, sif.o_spi_miso, sif.o_busy, sif.o_rd_timeout}), 32'd0);
    @(negedge clk);
    sif.i_spi_cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int f = 0; f < 24; f++) begin
      len = $urandom_range(15, 0);
      a   = (f % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      ab  = 0;
      if ($urandom_range(1, 0) == 1) begin
        c = {1'b1, 3'b000, 4'(len)};
        for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
        if ($urandom_range(3, 0) == 0) ab = $urandom_range(8 + AW + (len + 1) * DW - 1, 2);
      end else begin
        c = {1'b0, 3'b000, 4'(len)};
        never_resp = ($urandom_range(7, 0) == 0);
        salt = $urandom;
      end
      run_check(c, a, ab);
      never_resp = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
